// File: rtl/core_data_write_buffer.sv
// Posted-write FIFO between the core data port and the bus router; loads pass straight through once ordering is safe.
// Optional WBUF_RD_BYPASS_EN lets loads to words with no buffered store overtake pending stores.
module core_data_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_rd_req,
  output logic                       s_rd_gnt,
  input  logic [31:0]                s_rd_addr,
  output logic [31:0]                s_rd_data,
  input  logic                       s_wr_req,
  output logic                       s_wr_gnt,
  input  logic [31:0]                s_wr_addr,
  input  logic [31:0]                s_wr_data,
  input  logic [3:0]                 s_wr_be,
  output logic                       m_rd_req,
  input  logic                       m_rd_gnt,
  output logic [31:0]                m_rd_addr,
  input  logic [31:0]                m_rd_data,
  output logic                       m_wr_req,
  input  logic                       m_wr_gnt,
  output logic [31:0]                m_wr_addr,
  output logic [31:0]                m_wr_data,
  output logic [3:0]                 m_wr_be,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_be   [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_hit;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_push   = s_wr_req & ~w_full;
  assign w_pop    = (r_count != '0) & m_wr_gnt;

  assign s_wr_gnt = w_push;
  assign m_wr_req = (r_count != '0);
  assign m_wr_addr = r_addr[r_rd_ptr];
  assign m_wr_data = r_data[r_rd_ptr];
  assign m_wr_be   = r_be[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

  // Entry storage carries no reset; validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= s_wr_addr;
      r_data[r_wr_ptr] <= s_wr_data;
      r_be[r_wr_ptr]   <= s_wr_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

`ifdef WBUF_RD_BYPASS_EN
  // An entry is live when its distance from the head is below count.
  always_comb begin
    w_hit = s_wr_req;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(i) - r_rd_ptr) < r_count) &&
          (r_addr[i][31:2] == s_rd_addr[31:2]))
        w_hit = 1'b1;
    end
  end
`else
  assign w_hit = s_wr_req | (r_count != '0);
`endif

  assign m_rd_req  = s_rd_req & ~w_hit;
  assign m_rd_addr = s_rd_addr;
  assign s_rd_gnt  = m_rd_req & m_rd_gnt;
  assign s_rd_data = m_rd_data;

endmodule

// File: tb/tb_core_data_write_buffer.sv
// Directed bench for core_data_write_buffer: bus write sink plus a word memory model feeding reads.
// Define WBUF_RD_BYPASS_EN for both files to exercise the load-bypass build.
module tb_core_data_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_rd_req, s_rd_gnt;
  logic [31:0] s_rd_addr, s_rd_data;
  logic        s_wr_req, s_wr_gnt;
  logic [31:0] s_wr_addr, s_wr_data;
  logic [3:0]  s_wr_be;
  logic        m_rd_req, m_rd_gnt;
  logic [31:0] m_rd_addr;
  logic [31:0] m_rd_data = 32'h0;
  logic        m_wr_req, m_wr_gnt;
  logic [31:0] m_wr_addr, m_wr_data;
  logic [3:0]  m_wr_be;
  logic [2:0]  o_count;
  logic        o_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [67:0] sink_q [$];
  logic [31:0] bus_mem [logic [31:0]];

  core_data_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rd_req(s_rd_req), .s_rd_gnt(s_rd_gnt), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_gnt(s_wr_gnt), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .s_wr_be(s_wr_be),
    .m_rd_req(m_rd_req), .m_rd_gnt(m_rd_gnt), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_gnt(m_wr_gnt), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_be(m_wr_be),
    .o_count(o_count), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  // Bus sink records accepted writes; read side returns memory contents one cycle after grant.
  always @(posedge clk) begin
    if (m_wr_req && m_wr_gnt) begin
      sink_q.push_back({m_wr_addr, m_wr_data, m_wr_be});
      bus_mem[{m_wr_addr[31:2], 2'b00}] = m_wr_data;
    end
    if (m_rd_req && m_rd_gnt)
      m_rd_data <= bus_mem.exists({m_rd_addr[31:2], 2'b00}) ? bus_mem[{m_rd_addr[31:2], 2'b00}] : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    s_wr_req  = 1'b1;
    s_wr_addr = a;
    s_wr_data = d;
    s_wr_be   = 4'hF;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    m_wr_gnt = 1'b1;
    while (!o_empty && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_done", {31'b0, o_empty}, 32'd1);
  endtask

  task automatic check_sink(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (sink_q.size() > idx) begin
      check({tag, "_addr"}, sink_q[idx][67:36], a);
      check({tag, "_data"}, sink_q[idx][35:4], d);
    end else begin
      check({tag, "_missing"}, sink_q.size(), idx + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_rd_req = 1'b0; s_rd_addr = 32'h0;
    s_wr_req = 1'b0; s_wr_addr = 32'h0; s_wr_data = 32'h0; s_wr_be = 4'h0;
    m_rd_gnt = 1'b1; m_wr_gnt = 1'b1;
    #12;
    check("rst_m_wr_req", {31'b0, m_wr_req}, 0);
    check("rst_empty", {31'b0, o_empty}, 1);
    check("rst_count", {29'b0, o_count}, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: single store, immediate drain
    wr(32'h1000, 32'hDEADBEEF);
    #1;
    check("t1_gnt", {31'b0, s_wr_gnt}, 1);
    check("t1_no_req_same_cycle", {31'b0, m_wr_req}, 0);
    tick();
    s_wr_req = 1'b0;
    #1;
    check("t1_m_wr_req", {31'b0, m_wr_req}, 1);
    check("t1_addr", m_wr_addr, 32'h1000);
    check("t1_data", m_wr_data, 32'hDEADBEEF);
    check("t1_be", {28'b0, m_wr_be}, 32'hF);
    check("t1_count1", {29'b0, o_count}, 1);
    tick();
    check("t1_count0", {29'b0, o_count}, 0);
    check("t1_empty", {31'b0, o_empty}, 1);
    check_sink("t1_sink", 0, 32'h1000, 32'hDEADBEEF);

    // 2: fill to full, fifth store waits for first pop
    sink_q.delete();
    m_wr_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      #1;
      check("t2_gnt", {31'b0, s_wr_gnt}, 1);
      tick();
    end
    wr(32'h110, 32'hA4);
    #1;
    check("t2_full_gnt", {31'b0, s_wr_gnt}, 0);
    check("t2_count4", {29'b0, o_count}, 4);
    m_wr_gnt = 1'b1;
    #1;
    check("t2_no_push_through", {31'b0, s_wr_gnt}, 0);
    tick();
    check("t2_count3", {29'b0, o_count}, 3);
    check("t2_fifth_gnt", {31'b0, s_wr_gnt}, 1);
    check("t2_head", m_wr_addr, 32'h104);
    tick();
    s_wr_req = 1'b0;
    check("t2_count_pushpop", {29'b0, o_count}, 3);
    drain(20);
    for (int k = 0; k < 5; k++)
      check_sink("t2_order", k, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));

    // 4: push and pop together at count 2
    sink_q.delete();
    m_wr_gnt = 1'b0;
    wr(32'h400, 32'h11); tick();
    wr(32'h404, 32'h22); tick();
    check("t4_count2", {29'b0, o_count}, 2);
    m_wr_gnt = 1'b1;
    wr(32'h408, 32'h33);
    tick();
    s_wr_req = 1'b0;
    m_wr_gnt = 1'b0;
    #1;
    check("t4_count_stays", {29'b0, o_count}, 2);
    drain(20);
    check_sink("t4_order0", 0, 32'h400, 32'h11);
    check_sink("t4_order1", 1, 32'h404, 32'h22);
    check_sink("t4_order2", 2, 32'h408, 32'h33);

    // 3: load held behind buffered store to same word
    m_wr_gnt = 1'b0;
    wr(32'h2000, 32'h55);
    tick();
    s_wr_req = 1'b0;
    s_rd_req = 1'b1; s_rd_addr = 32'h2000;
    #1;
    check("t3_rd_blocked", {31'b0, m_rd_req}, 0);
    check("t3_rd_gnt_blocked", {31'b0, s_rd_gnt}, 0);
    check("t3_count1", {29'b0, o_count}, 1);
    tick();
    check("t3_rd_still_blocked", {31'b0, m_rd_req}, 0);
    m_wr_gnt = 1'b1;
    tick();
    check("t3_empty", {31'b0, o_empty}, 1);
    check("t3_rd_req", {31'b0, m_rd_req}, 1);
    check("t3_rd_gnt", {31'b0, s_rd_gnt}, 1);
    check("t3_rd_addr", m_rd_addr, 32'h2000);
    tick();
    check("t3_rd_data", s_rd_data, 32'h55);
    wr(32'h2100, 32'h66);
    #1;
    check("t3_collision_rd", {31'b0, m_rd_req}, 0);
    check("t3_collision_wr", {31'b0, s_wr_gnt}, 1);
    tick();
    s_wr_req = 1'b0; s_rd_req = 1'b0;
    drain(10);

    // 5: async reset with three stores buffered
    sink_q.delete();
    m_wr_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr(32'h500 + 32'(4 * k), 32'h70 + 32'(k));
      tick();
    end
    s_wr_req = 1'b0;
    check("t5_count3", {29'b0, o_count}, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_req", {31'b0, m_wr_req}, 0);
    check("t5_rst_count", {29'b0, o_count}, 0);
    check("t5_rst_empty", {31'b0, o_empty}, 1);
    #2 rst_n = 1'b1;
    m_wr_gnt = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (m_wr_req) seen++;
      end
      check("t5_no_req_after", 32'(seen), 0);
    end
    check("t5_sink_empty", sink_q.size(), 0);

    // 6: load ordering against a pending store at 0x2000
    m_wr_gnt = 1'b0;
    wr(32'h2000, 32'h77);
    tick();
    s_wr_req = 1'b0;
    s_rd_req = 1'b1;
    s_rd_addr = 32'h3000;
    #1;
`ifdef WBUF_RD_BYPASS_EN
    check("t6_other_word", {31'b0, m_rd_req}, 1);
`else
    check("t6_other_word", {31'b0, m_rd_req}, 0);
`endif
    s_rd_addr = 32'h2004;
    #1;
`ifdef WBUF_RD_BYPASS_EN
    check("t6_next_word", {31'b0, m_rd_req}, 1);
`else
    check("t6_next_word", {31'b0, m_rd_req}, 0);
`endif
    s_rd_addr = 32'h2002;
    #1;
    check("t6_same_word", {31'b0, m_rd_req}, 0);
    m_wr_gnt = 1'b1;
    tick();
    check("t6_after_drain", {31'b0, m_rd_req}, 1);
    tick();
    check("t6_rd_data", s_rd_data, 32'h77);
    s_rd_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
